// File: rtl/multi_pwm_drive_pkg.sv
// Shared types and default parameters for the multi-channel H-bridge PWM driver.
package pwm_drive_pkg;

   // Per-channel bridge mode, encoded as on the mode input bus
   typedef enum logic [1:0] {
      MODE_COAST = 2'b00,
      MODE_FWD   = 2'b01,
      MODE_REV   = 2'b10,
      MODE_BRAKE = 2'b11
   } mode_e;

   // Applied rotation direction (the leg that carries PWM)
   typedef enum logic {
      DIR_FWD = 1'b0,
      DIR_REV = 1'b1
   } dir_e;

   localparam int DEF_CHANNELS  = 2;
   localparam int DEF_DUTY_W    = 5;
   localparam int DEF_PRESCALE  = 1028;
   localparam int DEF_RAMP_STEP = 1;

   // Direction requested by a driving mode; non-driving modes report forward
   function automatic dir_e dir_of(input mode_e m);
      return (m == MODE_REV) ? DIR_REV : DIR_FWD;
   endfunction

endpackage

// File: rtl/multi_pwm_drive_if.sv
// Control/drive bundle between the control logic (master) and the PWM driver (slave).
interface multi_pwm_drive_if #(
   parameter int CHANNELS = 2,
   parameter int DUTY_W   = 5
);
   logic                         enable;
   logic [CHANNELS*DUTY_W-1:0]   duty_cycle;
   logic [2*CHANNELS-1:0]        mode;
   logic [CHANNELS-1:0]          motor_a;
   logic [CHANNELS-1:0]          motor_b;
   logic                         period_start;
   logic [CHANNELS-1:0]          settled;

   modport master (
      output enable, duty_cycle, mode,
      input  motor_a, motor_b, period_start, settled
   );

   modport slave (
      input  enable, duty_cycle, mode,
      output motor_a, motor_b, period_start, settled
   );
endinterface

// File: rtl/multi_pwm_drive_channel.sv
// One H-bridge channel: target sampling, soft-start ramp with reversal
// protection, PWM compare and registered leg encoding.
module pwm_drive_channel
   import pwm_drive_pkg::*;
#(
   parameter int DUTY_W    = DEF_DUTY_W,
   parameter int RAMP_STEP = DEF_RAMP_STEP
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              boundary,
   input  logic [DUTY_W-1:0] phase,
   input  logic [DUTY_W-1:0] duty_in,
   input  mode_e             mode_in,
   output logic              motor_a,
   output logic              motor_b,
   output logic              settled
);

   // A step larger than the duty range behaves like a full-range step
   localparam int                MAX_DUTY = (1 << DUTY_W) - 1;
   localparam int                STEP_C   = (RAMP_STEP > MAX_DUTY) ? MAX_DUTY : RAMP_STEP;
   localparam logic [DUTY_W-1:0] STEP     = DUTY_W'(STEP_C);

   logic [DUTY_W-1:0] tgt_duty;
   mode_e             tgt_mode;
   logic [DUTY_W-1:0] cur_duty;
   dir_e              cur_dir;

   logic [DUTY_W-1:0] nxt_duty;
   dir_e              nxt_dir;
   logic              pwm;
   logic              leg_a;
   logic              leg_b;

   // Next applied duty/direction from the freshly sampled inputs
   always_comb begin
      nxt_duty = cur_duty;
      nxt_dir  = cur_dir;
      case (mode_in)
         MODE_FWD, MODE_REV: begin
            if (dir_of(mode_in) != cur_dir) begin
               // Reversal: wind down first, flip only once duty has reached 0
               if (cur_duty == '0)
                  nxt_dir = dir_of(mode_in);
               else if (cur_duty > STEP)
                  nxt_duty = cur_duty - STEP;
               else
                  nxt_duty = '0;
            end else if (duty_in > cur_duty) begin
               nxt_duty = (duty_in - cur_duty > STEP) ? cur_duty + STEP : duty_in;
            end else if (duty_in < cur_duty) begin
               nxt_duty = (cur_duty - duty_in > STEP) ? cur_duty - STEP : duty_in;
            end
         end
         default: nxt_duty = '0;
      endcase
   end

   assign pwm = (phase < cur_duty);

   // Leg drive; PWM only ever lands on the leg of the applied direction
   always_comb begin
      leg_a = 1'b0;
      leg_b = 1'b0;
      case (tgt_mode)
         MODE_COAST: begin
            leg_a = 1'b0;
            leg_b = 1'b0;
         end
         MODE_BRAKE: begin
            leg_a = 1'b1;
            leg_b = 1'b1;
         end
         default: begin
            if (cur_dir == DIR_FWD)
               leg_a = pwm;
            else
               leg_b = pwm;
         end
      endcase
   end

   // Targets and ramp update at period boundaries; legs registered every clock
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tgt_duty <= '0;
         tgt_mode <= MODE_COAST;
         cur_duty <= '0;
         cur_dir  <= DIR_FWD;
         motor_a  <= 1'b0;
         motor_b  <= 1'b0;
      end else if (!enable) begin
         tgt_duty <= '0;
         tgt_mode <= MODE_COAST;
         cur_duty <= '0;
         motor_a  <= 1'b0;
         motor_b  <= 1'b0;
      end else begin
         if (boundary) begin
            tgt_duty <= duty_in;
            tgt_mode <= mode_in;
            cur_duty <= nxt_duty;
            cur_dir  <= nxt_dir;
         end
         motor_a <= leg_a;
         motor_b <= leg_b;
      end
   end

   assign settled = (cur_duty == tgt_duty) &&
                    ((tgt_mode == MODE_COAST) || (tgt_mode == MODE_BRAKE) ||
                     (cur_dir == dir_of(tgt_mode)));

endmodule

// File: rtl/multi_pwm_drive.sv
// N-channel H-bridge PWM driver: shared prescaler/phase timebase feeding
// one ramping channel per bridge.
module multi_pwm_drive
   import pwm_drive_pkg::*;
#(
   parameter int CHANNELS  = DEF_CHANNELS,
   parameter int DUTY_W    = DEF_DUTY_W,
   parameter int PRESCALE  = DEF_PRESCALE,
   parameter int RAMP_STEP = DEF_RAMP_STEP
) (
   input logic               clk_3125KHz,
   input logic               reset_n,
   multi_pwm_drive_if.slave  bus
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [PW-1:0]       presc;
   logic [DUTY_W-1:0]   phase;
   logic                en_q;
   logic                ps_q;
   logic                run;
   logic                tick;
   logic                boundary;
   logic [CHANNELS-1:0] ma;
   logic [CHANNELS-1:0] mb;
   logic [CHANNELS-1:0] st;

   // The first enabled clock after a disable is a restart clock: it only
   // raises period_start, so the restarted period begins at phase 0.
   assign run      = bus.enable && en_q;
   assign tick     = run && (presc == PW'(PRESCALE - 1));
   assign boundary = tick && (phase == '1);

   // Shared timebase; en_q resets high since reset already leaves phase 0
   always_ff @(posedge clk_3125KHz or negedge reset_n) begin
      if (!reset_n) begin
         presc <= '0;
         phase <= '0;
         en_q  <= 1'b1;
         ps_q  <= 1'b0;
      end else if (!bus.enable) begin
         presc <= '0;
         phase <= '0;
         en_q  <= 1'b0;
         ps_q  <= 1'b0;
      end else if (!en_q) begin
         en_q  <= 1'b1;
         ps_q  <= 1'b1;
      end else begin
         ps_q <= boundary;
         if (tick) begin
            presc <= '0;
            phase <= phase + 1'b1;
         end else begin
            presc <= presc + 1'b1;
         end
      end
   end

   for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
      pwm_drive_channel #(
         .DUTY_W    (DUTY_W),
         .RAMP_STEP (RAMP_STEP)
      ) u_ch (
         .clk      (clk_3125KHz),
         .rst_n    (reset_n),
         .enable   (bus.enable),
         .boundary (boundary),
         .phase    (phase),
         .duty_in  (bus.duty_cycle[k*DUTY_W +: DUTY_W]),
         .mode_in  (mode_e'(bus.mode[2*k +: 2])),
         .motor_a  (ma[k]),
         .motor_b  (mb[k]),
         .settled  (st[k])
      );
   end

   assign bus.motor_a      = ma;
   assign bus.motor_b      = mb;
   assign bus.settled      = st;
   assign bus.period_start = ps_q;

endmodule

// File: tb/tb_multi_pwm_drive.sv
// Directed bench for multi_pwm_drive: DUTY_W=3, PRESCALE=2 (16-clock period),
// one instance with RAMP_STEP=1 and one with RAMP_STEP=3.
module tb_multi_pwm_drive;

   logic clk = 1'b0;
   logic reset_n;
   int   errors = 0;
   int   checks = 0;
   int   ca [2];
   int   cb [2];
   int   cov [2];
   int   n;

   always #5 clk = ~clk;

   multi_pwm_drive_if #(.CHANNELS(2), .DUTY_W(3)) bus1 ();
   multi_pwm_drive_if #(.CHANNELS(2), .DUTY_W(3)) bus2 ();

   multi_pwm_drive #(.CHANNELS(2), .DUTY_W(3), .PRESCALE(2), .RAMP_STEP(1)) u1 (
      .clk_3125KHz (clk),
      .reset_n     (reset_n),
      .bus         (bus1)
   );

   multi_pwm_drive #(.CHANNELS(2), .DUTY_W(3), .PRESCALE(2), .RAMP_STEP(3)) u2 (
      .clk_3125KHz (clk),
      .reset_n     (reset_n),
      .bus         (bus2)
   );

   // Per-period expectations for u1 ch0 (period 1..19)
   int t_a  [19] = '{2,4,6,8,8,16,2,4,6,8,6,4,2,0,0,0,0,0,0};
   int t_b  [19] = '{0,0,0,0,0,16,0,0,0,0,0,0,0,0,0,2,4,6,8};
   int t_s  [19] = '{0,0,0,1,1,1,0,1,0,1,0,0,0,0,0,0,0,0,1};
   int t_md [19] = '{-1,-1,-1,-1,3,1,-1,1,-1,2,-1,-1,-1,-1,-1,-1,-1,-1,-1};
   int t_dt [19] = '{0,0,0,0,0,2,0,4,0,4,0,0,0,0,0,0,0,0,0};

   // u2 expectations (period 1..4): ch0 fwd 7, ch1 rev 2, RAMP_STEP=3
   int u_a0 [4] = '{6,12,14,14};
   int u_b1 [4] = '{0,4,4,4};
   int u_s  [4] = '{0,2,3,3};

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic get_ps(input int which);
      return (which == 2) ? bus2.period_start : bus1.period_start;
   endfunction

   // Advance negedges until period_start is seen (no advance if already high)
   task automatic wait_ps(input int which, output int cnt);
      cnt = 0;
      while (get_ps(which) !== 1'b1 && cnt < 40) begin
         @(negedge clk);
         cnt++;
      end
      if (cnt >= 40) chk($sformatf("u%0d period_start timeout", which), 0, 1);
   endtask

   // Count leg-high clocks over one 16-clock period window
   task automatic count_period(input int which);
      logic [1:0] a;
      logic [1:0] b;
      for (int c = 0; c < 2; c++) begin
         ca[c] = 0; cb[c] = 0; cov[c] = 0;
      end
      repeat (16) begin
         @(negedge clk);
         a = (which == 2) ? bus2.motor_a : bus1.motor_a;
         b = (which == 2) ? bus2.motor_b : bus1.motor_b;
         for (int c = 0; c < 2; c++) begin
            ca[c]  += int'(a[c]);
            cb[c]  += int'(b[c]);
            cov[c] += int'(a[c] & b[c]);
         end
      end
   endtask

   initial begin
      reset_n          = 1'b0;
      bus1.enable      = 1'b1;
      bus1.duty_cycle  = '0;
      bus1.mode        = '0;
      bus2.enable      = 1'b1;
      bus2.duty_cycle  = '0;
      bus2.mode        = '0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst motor_a", int'(bus1.motor_a), 0);
      chk("rst motor_b", int'(bus1.motor_b), 0);
      chk("rst period_start", int'(bus1.period_start), 0);
      chk("rst settled", int'(bus1.settled), 3);
      chk("rst u2 settled", int'(bus2.settled), 3);

      // ch0 forward 4, release reset; first boundary 16 clocks later
      bus1.mode[1:0]       = 2'b01;
      bus1.duty_cycle[2:0] = 3'd4;
      reset_n = 1'b1;
      wait_ps(1, n);
      chk("first period_start delay", n, 16);

      // Ramp, brake, re-ramp and reversal, one period per row
      for (int i = 0; i < 19; i++) begin
         wait_ps(1, n);
         chk($sformatf("u1 p%0d settled0", i+1), int'(bus1.settled[0]), t_s[i]);
         if (t_md[i] >= 0) begin
            bus1.mode[1:0]       = 2'(t_md[i]);
            bus1.duty_cycle[2:0] = 3'(t_dt[i]);
         end
         count_period(1);
         chk($sformatf("u1 p%0d a0 high", i+1), ca[0], t_a[i]);
         chk($sformatf("u1 p%0d b0 high", i+1), cb[0], t_b[i]);
         chk($sformatf("u1 p%0d a0&b0", i+1), cov[0], (t_a[i] == 16) ? 16 : 0);
         chk($sformatf("u1 p%0d ch1 idle", i+1), ca[1] + cb[1], 0);
      end

      // Asynchronous reset mid-period while reverse leg is driving
      repeat (3) @(negedge clk);
      chk("pre-reset motor_b0", int'(bus1.motor_b[0]), 1);
      #2 reset_n = 1'b0;
      #1;
      chk("async rst motor_a", int'(bus1.motor_a), 0);
      chk("async rst motor_b", int'(bus1.motor_b), 0);
      chk("async rst settled", int'(bus1.settled), 3);
      bus1.mode[1:0]       = 2'b01;
      bus1.duty_cycle[2:0] = 3'd4;
      @(negedge clk);
      reset_n = 1'b1;
      wait_ps(1, n);
      chk("post-reset period_start delay", n, 16);
      count_period(1);
      chk("post-reset p1 a0", ca[0], 2);
      count_period(1);
      chk("post-reset p2 a0", ca[0], 4);

      // enable dropped mid-period, then restored
      repeat (5) @(negedge clk);
      bus1.enable = 1'b0;
      @(negedge clk);
      chk("disable motor_a", int'(bus1.motor_a), 0);
      chk("disable motor_b", int'(bus1.motor_b), 0);
      chk("disable settled", int'(bus1.settled), 3);
      chk("disable period_start", int'(bus1.period_start), 0);
      repeat (3) @(negedge clk);
      bus1.enable = 1'b1;
      @(negedge clk);
      chk("enable period_start", int'(bus1.period_start), 1);
      wait_ps(1, n);
      count_period(1);
      chk("restart p0 a0", ca[0], 0);
      wait_ps(1, n);
      count_period(1);
      chk("restart p1 a0", ca[0], 2);

      // RAMP_STEP=3: ch0 forward 7, ch1 reverse 2
      bus2.duty_cycle = {3'd2, 3'd7};
      bus2.mode       = {2'b10, 2'b01};
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         wait_ps(2, n);
         chk($sformatf("u2 p%0d settled", i+1), int'(bus2.settled), u_s[i]);
         count_period(2);
         chk($sformatf("u2 p%0d a0 high", i+1), ca[0], u_a0[i]);
         chk($sformatf("u2 p%0d b1 high", i+1), cb[1], u_b1[i]);
         chk($sformatf("u2 p%0d wrong legs", i+1), cb[0] + ca[1], 0);
         chk($sformatf("u2 p%0d overlap", i+1), cov[0] + cov[1], 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
